// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arithmetic ops, an iterative rotate (ROTN5)
// and a shift-add multiplier (MUL4). Results and flags are registered.
module multicycle_alu #(
  parameter int WIDTH        = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  input  logic [WIDTH-1:0]        register1Value,
  input  logic [WIDTH-1:0]        register2Value,
  input  logic [WIDTH-1:0]        instructionValue,
  input  logic                    switch,
  output logic                    ready,
  output logic                    resultValid,
  output logic [WIDTH-1:0]        aluResult,
  output logic                    zero,
  output logic                    carry
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD0  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD    = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB    = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL    = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ROTN   = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR     = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDSW   = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND    = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR    = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_INC    = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_LSHIFT = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_DEC    = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OP_RSHIFT = OPCODE_WIDTH'(15);

  typedef enum logic [1:0] {IDLE, ROTATE, MULTIPLY} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [WIDTH-1:0]  work_reg, work_next;   // rotate value, or multiplicand
  logic [WIDTH-1:0]  mplr_reg, mplr_next;   // multiplier shifting out / product low half
  logic [WIDTH-1:0]  hi_reg, hi_next;       // product high half
  logic [WIDTH-1:0]  result_reg, result_next;
  logic              zero_reg, zero_next;
  logic              carry_reg, carry_next;
  logic              valid_reg, valid_next;

  logic [WIDTH:0]    ext;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH-1:0]  mul_lo;
  logic [CW-1:0]     rot_n;
  logic [WIDTH-1:0]  rot_work;

  assign mul_sum  = {1'b0, hi_reg} + ({1'b0, work_reg} & {(WIDTH+1){mplr_reg[0]}});
  assign mul_lo   = {mul_sum[0], mplr_reg[WIDTH-1:1]};
  assign rot_n    = CW'(register2Value % WIDTH_V);
  assign rot_work = {work_reg[WIDTH-2:0], work_reg[WIDTH-1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      work_reg   <= '0;
      mplr_reg   <= '0;
      hi_reg     <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      carry_reg  <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      work_reg   <= work_next;
      mplr_reg   <= mplr_next;
      hi_reg     <= hi_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      carry_reg  <= carry_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    work_next   = work_reg;
    mplr_next   = mplr_reg;
    hi_next     = hi_reg;
    result_next = result_reg;
    carry_next  = carry_reg;
    valid_next  = 1'b0;
    ext         = '0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          valid_next = 1'b1;
          carry_next = 1'b0;
          case (opCode)
            OP_LOAD0:  result_next = instructionValue;
            OP_ADD: begin
              ext         = {1'b0, register1Value} + {1'b0, register2Value};
              result_next = ext[WIDTH-1:0];
              carry_next  = ext[WIDTH];
            end
            OP_SUB: begin
              ext         = {1'b0, register1Value} - {1'b0, register2Value};
              result_next = ext[WIDTH-1:0];
              carry_next  = ext[WIDTH];
            end
            OP_MUL: begin
              valid_next = 1'b0;
              carry_next = carry_reg;
              work_next  = register1Value;
              mplr_next  = register2Value;
              hi_next    = '0;
              count_next = CW'(WIDTH - 1);
              state_next = MULTIPLY;
            end
            OP_ROTN: begin
              if (rot_n == '0) begin
                result_next = register1Value;
              end else begin
                // Outputs keep their old values until the rotation completes.
                valid_next = 1'b0;
                carry_next = carry_reg;
                work_next  = register1Value;
                count_next = rot_n - CW'(1);
                state_next = ROTATE;
              end
            end
            OP_OR:     result_next = register1Value | register2Value;
            OP_LDSW:   result_next = {{(WIDTH-1){1'b0}}, switch};
            OP_AND:    result_next = register1Value & register2Value;
            OP_XOR:    result_next = register1Value ^ register2Value;
            OP_INC: begin
              ext         = {1'b0, register1Value} + {{WIDTH{1'b0}}, 1'b1};
              result_next = ext[WIDTH-1:0];
              carry_next  = ext[WIDTH];
            end
            OP_LSHIFT: result_next = {register1Value[WIDTH-2:0], register1Value[WIDTH-1]};
            OP_DEC: begin
              ext         = {1'b0, register1Value} - {{WIDTH{1'b0}}, 1'b1};
              result_next = ext[WIDTH-1:0];
              carry_next  = ext[WIDTH];
            end
            OP_RSHIFT: result_next = {register1Value[0], register1Value[WIDTH-1:1]};
            default:   result_next = '0;
          endcase
        end
      end

      ROTATE: begin
        work_next = rot_work;
        if (count_reg == '0) begin
          result_next = rot_work;
          carry_next  = 1'b0;
          valid_next  = 1'b1;
          state_next  = IDLE;
        end else begin
          count_next = count_reg - CW'(1);
        end
      end

      MULTIPLY: begin
        hi_next   = mul_sum[WIDTH:1];
        mplr_next = mul_lo;
        if (count_reg == '0) begin
          result_next = mul_lo;
          carry_next  = |mul_sum[WIDTH:1];
          valid_next  = 1'b1;
          state_next  = IDLE;
        end else begin
          count_next = count_reg - CW'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign zero_next = (result_next == '0);

  assign ready       = (state_reg == IDLE);
  assign resultValid = valid_reg;
  assign aluResult   = result_reg;
  assign zero        = zero_reg;
  assign carry       = carry_reg;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH=8; outputs are
// sampled on the falling clock edge, inputs driven there too.
module tb_multicycle_alu;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] opCode;
  logic [7:0] register1Value;
  logic [7:0] register2Value;
  logic [7:0] instructionValue;
  logic       switch;
  logic       ready;
  logic       resultValid;
  logic [7:0] aluResult;
  logic       zero;
  logic       carry;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_alu #(.WIDTH(8), .OPCODE_WIDTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .opCode(opCode),
    .register1Value(register1Value),
    .register2Value(register2Value),
    .instructionValue(instructionValue),
    .switch(switch),
    .ready(ready),
    .resultValid(resultValid),
    .aluResult(aluResult),
    .zero(zero),
    .carry(carry)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operation for a single cycle, then scramble the inputs so a
  // design that does not capture operands at acceptance is exposed.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] imm, input logic sw);
    opCode = op; register1Value = a; register2Value = b;
    instructionValue = imm; switch = sw; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    register1Value = 8'($urandom); register2Value = 8'($urandom);
    instructionValue = 8'($urandom); switch = 1'($urandom);
    opCode = 4'($urandom);
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic sw,
                        input logic [7:0] er, input logic ec);
    issue(op, a, b, 8'h5A, sw);
    $display("op=%0d a=%02h b=%02h sw=%0b -> result=%02h carry=%0b zero=%0b valid=%0b",
             op, a, b, sw, aluResult, carry, zero, resultValid);
    check({tag, " valid"}, resultValid, 1);
    check({tag, " result"}, aluResult, er);
    check({tag, " carry"}, carry, ec);
    check({tag, " zero"}, zero, (er == 8'h00));
    check({tag, " ready"}, ready, 1);
  endtask

  initial begin
    // Reset with a start pending: the start must be dropped.
    reset = 1'b1; start = 1'b1; opCode = 4'd2;
    register1Value = 8'h01; register2Value = 8'h01;
    instructionValue = 8'h00; switch = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    $display("reset released: ready=%0b valid=%0b result=%02h zero=%0b carry=%0b",
             ready, resultValid, aluResult, zero, carry);
    check("rst ready", ready, 1);
    check("rst valid", resultValid, 0);
    check("rst result", aluResult, 8'h00);
    check("rst zero", zero, 1);
    check("rst carry", carry, 0);

    // ADD with carry out, valid for exactly one cycle, result held afterwards
    single("add_f0_20", 4'd2, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1);
    @(negedge clock);
    check("add pulse end", resultValid, 0);
    check("add hold", aluResult, 8'h10);

    // Single-cycle op table; ordering makes carry toggle so clears are visible
    single("load0",    4'd0,  8'h11, 8'h22, 1'b0, 8'h5A, 1'b0);
    single("add_ff",   4'd2,  8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
    single("or",       4'd6,  8'hA0, 8'h05, 1'b0, 8'hA5, 1'b0);
    single("inc_wrap", 4'd11, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1);
    single("ldsw",     4'd7,  8'h77, 8'h00, 1'b1, 8'h01, 1'b0);
    single("sub_brw",  4'd3,  8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    single("and",      4'd8,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0);
    single("dec_zero", 4'd14, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1);
    single("xor",      4'd9,  8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0);
    single("add_wrap", 4'd2,  8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    single("lshift",   4'd13, 8'h81, 8'h00, 1'b0, 8'h03, 1'b0);
    single("sub",      4'd3,  8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
    single("inc",      4'd11, 8'h7F, 8'h00, 1'b0, 8'h80, 1'b0);
    single("add_c",    4'd2,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    single("op1",      4'd1,  8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    single("rshift",   4'd15, 8'h81, 8'h00, 1'b0, 8'hC0, 1'b0);
    single("inc_ff",   4'd11, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1);
    single("op12",     4'd12, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0);
    single("dec",      4'd14, 8'h10, 8'h00, 1'b0, 8'h0F, 1'b0);
    single("op10",     4'd10, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0);

    // Back-to-back: DEC 0x00 then SUB 5-5
    opCode = 4'd14; register1Value = 8'h00; register2Value = 8'h00; start = 1'b1;
    @(negedge clock);
    opCode = 4'd3; register1Value = 8'h05; register2Value = 8'h05;
    $display("b2b dec: result=%02h carry=%0b zero=%0b", aluResult, carry, zero);
    check("b2b dec valid", resultValid, 1);
    check("b2b dec result", aluResult, 8'hFF);
    check("b2b dec carry", carry, 1);
    check("b2b dec zero", zero, 0);
    @(negedge clock);
    start = 1'b0;
    $display("b2b sub: result=%02h carry=%0b zero=%0b", aluResult, carry, zero);
    check("b2b sub valid", resultValid, 1);
    check("b2b sub result", aluResult, 8'h00);
    check("b2b sub carry", carry, 0);
    check("b2b sub zero", zero, 1);

    // MUL 13*11 with start held high and different operands while busy
    @(negedge clock);
    opCode = 4'd4; register1Value = 8'd13; register2Value = 8'd11; start = 1'b1;
    @(negedge clock);
    opCode = 4'd2; register1Value = 8'hFF; register2Value = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mul busy ready c%0d", i + 1), ready, 0);
      check($sformatf("mul busy valid c%0d", i + 1), resultValid, 0);
      @(negedge clock);
    end
    start = 1'b0;
    $display("mul 13*11: result=%02h carry=%0b zero=%0b", aluResult, carry, zero);
    check("mul13 valid", resultValid, 1);
    check("mul13 result", aluResult, 8'h8F);
    check("mul13 carry", carry, 0);
    check("mul13 zero", zero, 0);
    check("mul13 ready", ready, 1);
    @(negedge clock);
    check("mul13 no queued", resultValid, 0);
    check("mul13 hold", aluResult, 8'h8F);

    // MUL 16*16 overflows into the high half
    issue(4'd4, 8'd16, 8'd16, 8'h00, 1'b0);
    repeat (8) @(negedge clock);
    $display("mul 16*16: result=%02h carry=%0b zero=%0b", aluResult, carry, zero);
    check("mul16 valid", resultValid, 1);
    check("mul16 result", aluResult, 8'h00);
    check("mul16 zero", zero, 1);
    check("mul16 carry", carry, 1);

    // ROTN by 11 mod 8 = 3
    issue(4'd5, 8'h81, 8'h0B, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rot busy ready c%0d", i + 1), ready, 0);
      check($sformatf("rot busy valid c%0d", i + 1), resultValid, 0);
      check($sformatf("rot no interim c%0d", i + 1), aluResult, 8'h00);
      @(negedge clock);
    end
    $display("rotn 81 by 3: result=%02h carry=%0b", aluResult, carry);
    check("rot3 valid", resultValid, 1);
    check("rot3 result", aluResult, 8'h0C);
    check("rot3 carry", carry, 0);

    // ROTN by 8 mod 8 = 0 completes in one cycle
    issue(4'd5, 8'h81, 8'h08, 8'h00, 1'b0);
    $display("rotn 81 by 0: result=%02h", aluResult);
    check("rot0 valid", resultValid, 1);
    check("rot0 result", aluResult, 8'h81);
    check("rot0 ready", ready, 1);

    // Reset at T+3 of a MUL aborts it
    issue(4'd4, 8'd13, 8'd11, 8'h00, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("mul aborted: ready=%0b valid=%0b result=%02h zero=%0b", ready, resultValid,
             aluResult, zero);
    check("abort ready", ready, 1);
    check("abort result", aluResult, 8'h00);
    check("abort zero", zero, 1);
    check("abort carry", carry, 0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("abort no valid c%0d", i), resultValid, 0);
      @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits, with a legal range of 4..32.
REQ-002 The block SHALL have parameter OPCODE_WIDTH, default 4, giving the opcode field width.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request an operation this cycle.
REQ-006 The block SHALL have port opCode, input, OPCODE_WIDTH bits: operation select.
REQ-007 The block SHALL have port register1Value, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port register2Value, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port instructionValue, input, WIDTH bits: immediate operand.
REQ-010 The block SHALL have port switch, input, 1 bit: external switch level.
REQ-011 The block SHALL have port ready, output, 1 bit: high when idle and able to accept start.
REQ-012 The block SHALL have port resultValid, output, 1 bit: one-cycle pulse marking a new result.
REQ-013 The block SHALL have port aluResult, output, WIDTH bits: registered result.
REQ-014 The block SHALL have port zero, output, 1 bit: registered flag, set when aluResult == 0.
REQ-015 The block SHALL have port carry, output, 1 bit: registered carry/borrow/overflow flag.

Function
REQ-016 The FSM SHALL have states IDLE, ROTATE and MULTIPLY; ready SHALL be 1 only in IDLE.
REQ-017 An operation SHALL be accepted on the cycle T where start=1 and ready=1; operands and opCode SHALL be captured at T, and input changes after T SHALL not affect the result.
REQ-018 start while ready=0 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-019 Single-cycle ops (FSM stays in IDLE) SHALL update aluResult/zero/carry and pulse resultValid at T+1; back-to-back starts every cycle SHALL be accepted.
REQ-020 Opcodes are decided as: LOAD0=0 result=instructionValue; ADD2=2 A+B, carry=bit WIDTH of sum; SUB3=3 A-B, carry=borrow (A<B unsigned); MUL4=4; ROTN5=5; OR6=6 A|B; LOADSWITCH7=7 result=switch zero-extended; AND8=8 bitwise A&B; XOR9=9 A^B; INCREMENT11=11 A+1, carry on wrap; LSHIFT13=13 rotate A left 1; DECREMENT14=14 A-1, carry=borrow on A==0; RSHIFT15=15 rotate A right 1.
REQ-021 All other opcodes SHALL produce result 0, carry 0, resultValid at T+1.
REQ-022 Logic, load and rotate ops SHALL clear carry; all arithmetic SHALL be modulo 2^WIDTH.
REQ-023 ROTN5 SHALL rotate A left by n = B mod WIDTH, one bit per cycle in state ROTATE with a down-counter; resultValid SHALL occur at T+1+n; n=0 SHALL skip ROTATE, giving result=A at T+1.
REQ-024 MUL4 SHALL be an unsigned shift-add over exactly WIDTH cycles in MULTIPLY, with resultValid at T+1+WIDTH; aluResult SHALL be the low WIDTH bits and carry=1 iff the high WIDTH bits of the 2*WIDTH product are nonzero.
REQ-025 On leaving ROTATE/MULTIPLY the FSM SHALL return to IDLE in the same cycle resultValid pulses, so ready=1 on that cycle.
REQ-026 aluResult, zero and carry SHALL hold their values between resultValid pulses, and intermediate values SHALL not appear on aluResult.
REQ-027 zero SHALL always equal (aluResult==0) whenever resultValid=1.

Reset
REQ-028 With reset=1 at a clock edge: state=IDLE, ready=1 on the next cycle, resultValid=0, aluResult=0, zero=1, carry=0, counters cleared.
REQ-029 Reset SHALL take priority over start in the same cycle, and that start SHALL be dropped.
REQ-030 Reset during ROTATE/MULTIPLY SHALL abort the operation with no resultValid pulse for it.

Verification (WIDTH=8)
REQ-031 The bench SHALL check ADD2 A=0xF0, B=0x20 -> at T+1 aluResult=0x10, carry=1, zero=0, resultValid=1 for exactly one cycle.
REQ-032 The bench SHALL check DECREMENT14 A=0x00 then SUB3 A=0x05, B=0x05 back-to-back -> result 0xFF/carry=1, then 0x00/zero=1/carry=0 on consecutive cycles.
REQ-033 The bench SHALL check MUL4 A=13, B=11 -> ready=0 for 8 cycles, aluResult=0x8F, carry=0 at T+9; MUL4 A=16, B=16 -> aluResult=0x00, zero=1, carry=1.
REQ-034 The bench SHALL check ROTN5 A=0x81, B=0x0B (n=3) -> aluResult=0x0C at T+4; with B=0x08 (n=0) -> aluResult=0x81 at T+1.
REQ-035 The bench SHALL check start held high during a MUL4 with different operands -> ignored, and the MUL4 result is unchanged.
REQ-036 The bench SHALL check reset asserted at T+3 of a MUL4 -> no resultValid, aluResult=0, zero=1, ready=1 on the cycle after reset is released.
